audio_period_decoder: RTL
=========================

// Module: audio_period_decoder
// PURPOSE
// Receive side of the 1-bit square-wave audio interface: recovers the half-period code (hp) and
// the note-active flag from an incoming audio line, i.e. the inverse of the synth path.
// Used for loopback self-test and for reading a second board's audio pin. Output hp uses the
// same 7-bit half-period units as the synth, measured in ticks of TICK_DIV clk cycles.
// PARAMETERS
// TICK_DIV       2048  clk cycles per measurement tick (equals one synth_clk period)
// GLITCH_CYC     4     clk cycles audio must hold a new level before it is accepted (1..7)
// TOL            1     max |meas - ref| in ticks counted as "same note"
// SILENCE_TICKS  200   ticks with no accepted edge before the decoder declares silence (128..255)
// PORTS
// clk        in   1  system clock
// rst        in   1  synchronous reset, active-high
// audio_in   in   1  square-wave audio, asynchronous to clk
// hp         out  7  decoded half-period in ticks; 0 when not locked
// active     out  1  1 while a note is locked
// note_stb   out  1  1-cycle pulse when hp takes a new locked value
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): hp=0, active=0, note_stb=0, state=IDLE, all counters 0,
//   filtered level=0, synchronizer flops=0. Reset mid-measurement discards everything.
// - Input: 2-flop synchronizer, then glitch filter: level change accepted only after GLITCH_CYC
//   consecutive cycles at the new level; accepted change = one-cycle internal `edge`.
//   Pulses shorter than GLITCH_CYC never produce an edge.
// - Prescaler pre (12 bit) counts 0..TICK_DIV-1; tick when pre==TICK_DIV-1. tcnt (8 bit) +1 per
//   tick, saturates at 255. On edge: meas=tcnt, then pre<=0, tcnt<=0 (realigns measurement).
// - meas in range iff 1 <= meas <= 127.
// - FSM (state, hp, active, note_stb all registered; update on cycle after edge):
//   IDLE   : edge -> ARMED (no measurement taken).
//   ARMED  : edge & in range -> CAND, cand<=meas; edge & out of range -> ARMED.
//   CAND   : edge & in range & |meas-cand|<=TOL -> LOCKED, hp<=meas, active<=1, note_stb=1;
//            edge & in range otherwise -> CAND, cand<=meas; edge & out of range -> ARMED.
//   LOCKED : edge & |meas-hp|<=TOL -> LOCKED, hp held (hysteresis, no strobe);
//            edge & in range otherwise -> CAND, cand<=meas, hp and active held;
//            edge & out of range -> ARMED, hp and active held.
//   Any state except IDLE: tcnt==SILENCE_TICKS (no edge) -> IDLE, hp<=0, active<=0, no strobe.
// - Edge and silence on the same cycle: edge wins (tcnt is cleared).
// - Re-lock to same hp from CAND (|meas-hp|<=TOL): hp<=meas, no strobe if meas==hp.
// - |a-b| computed in 8 bits unsigned (max-min), no wrap.
// - Latency: audio_in change -> edge = 2 + GLITCH_CYC clk; edge -> outputs = 1 clk.
// TESTING  (bench uses TICK_DIV=4, GLITCH_CYC=4, TOL=1, SILENCE_TICKS=200)
// 1 Reset held 5 cycles, audio_in toggling -> hp=0, active=0, note_stb=0 throughout.
// 2 Square wave half-period 188 clk (47 ticks) -> on 3rd edge hp=47, active=1, note_stb=1 for
//   exactly 1 cycle, 2+4+1 clk after the audio_in transition.
// 3 Locked at 47, half-periods 48,46,47,48 ticks -> hp stays 47, active=1, no further note_stb.
// 4 Locked at 47, switch to 70 ticks -> after 1st 70 edge hp=47, active=1; after 2nd hp=70,
//   note_stb pulse.
// 5 Locked at 47, audio_in frozen -> 200 ticks (800 clk) after last edge active=0, hp=0;
//   later toggling re-locks via IDLE->ARMED->CAND->LOCKED.
// 6 Locked at 47, 3-clk pulse injected mid-half-period -> no edge, hp=47, no strobe; plus
//   rst asserted mid-CAND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/audio_period_decoder.sv
// audio_period_decoder: recovers the half-period code and note-active flag from a
// 1-bit square-wave audio line (receive side of the synth audio path).
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   audio_in  square-wave audio, asynchronous to clk
//   hp        decoded half-period in ticks of TICK_DIV clk; 0 when not locked
//   active    1 while a note is locked
//   note_stb  1-cycle pulse when hp takes a new locked value
module audio_period_decoder #(
  parameter int unsigned TICK_DIV      = 2048,
  parameter int unsigned GLITCH_CYC    = 4,
  parameter int unsigned TOL           = 1,
  parameter int unsigned SILENCE_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       audio_in,
  output logic [6:0] hp,
  output logic       active,
  output logic       note_stb
);

  localparam int unsigned PRE_W  = 12;
  localparam int unsigned TCNT_W = 8;
  localparam int unsigned GCNT_W = 3;
  localparam int unsigned HP_W   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    CAND   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              edge_q, edge_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [HP_W-1:0]   cand_q, cand_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              active_q, active_d;
  logic              note_stb_q, note_stb_d;
  state_e            state_q, state_d;

  logic              tick;
  logic [TCNT_W-1:0] tcnt_adv;
  logic [TCNT_W-1:0] meas;
  logic              in_range;
  logic              near_cand;
  logic              near_hp;
  logic              silence;

  // Unsigned distance in 8 bits (max - min), never wraps.
  function automatic logic [TCNT_W-1:0] abs_diff(input logic [TCNT_W-1:0] a,
                                                 input logic [TCNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Synchronizer and glitch filter: a new level must persist GLITCH_CYC samples.
  always_comb begin
    sync1_d = audio_in;
    sync2_d = sync1_q;
    level_d = level_q;
    gcnt_d  = '0;
    edge_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (gcnt_q == GCNT_W'(GLITCH_CYC - 1)) begin
        level_d = sync2_q;
        edge_d  = 1'b1;
      end else begin
        gcnt_d = gcnt_q + GCNT_W'(1);
      end
    end
  end

  // Prescaler and tick counter; an edge realigns both to zero.
  // The measurement includes this cycle's tick so N*TICK_DIV clk reads as N.
  always_comb begin
    tick     = (pre_q == PRE_W'(TICK_DIV - 1));
    tcnt_adv = tcnt_q;
    if (tick && (tcnt_q != {TCNT_W{1'b1}})) begin
      tcnt_adv = tcnt_q + TCNT_W'(1);
    end
    meas = tcnt_adv;
    if (edge_q) begin
      pre_d  = '0;
      tcnt_d = '0;
    end else begin
      pre_d  = tick ? '0 : (pre_q + PRE_W'(1));
      tcnt_d = tcnt_adv;
    end
  end

  // Lock state machine next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    hp_d       = hp_q;
    active_d   = active_q;
    note_stb_d = 1'b0;
    in_range   = (meas != '0) && !meas[TCNT_W-1];
    near_cand  = abs_diff(meas, {1'b0, cand_q}) <= TCNT_W'(TOL);
    near_hp    = abs_diff(meas, {1'b0, hp_q}) <= TCNT_W'(TOL);
    silence    = (tcnt_q == TCNT_W'(SILENCE_TICKS));

    if (edge_q) begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (in_range) begin
            state_d = CAND;
            cand_d  = meas[HP_W-1:0];
          end
        end
        CAND: begin
          if (in_range && near_cand) begin
            state_d    = LOCKED;
            hp_d       = meas[HP_W-1:0];
            active_d   = 1'b1;
            // Re-locking onto the value already held is not a new note.
            note_stb_d = (meas[HP_W-1:0] != hp_q);
          end else if (in_range) begin
            cand_d = meas[HP_W-1:0];
          end else begin
            state_d = ARMED;
          end
        end
        LOCKED: begin
          if (near_hp) begin
            state_d = LOCKED;
          end else if (in_range) begin
            state_d = CAND;
            cand_d  = meas[HP_W-1:0];
          end else begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && silence) begin
      state_d  = IDLE;
      hp_d     = '0;
      active_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      gcnt_q     <= '0;
      edge_q     <= 1'b0;
      pre_q      <= '0;
      tcnt_q     <= '0;
      cand_q     <= '0;
      hp_q       <= '0;
      active_q   <= 1'b0;
      note_stb_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      gcnt_q     <= gcnt_d;
      edge_q     <= edge_d;
      pre_q      <= pre_d;
      tcnt_q     <= tcnt_d;
      cand_q     <= cand_d;
      hp_q       <= hp_d;
      active_q   <= active_d;
      note_stb_q <= note_stb_d;
      state_q    <= state_d;
    end
  end

  assign hp       = hp_q;
  assign active   = active_q;
  assign note_stb = note_stb_q;

endmodule
